// File: rtl/ram_sync_clear_pkg.sv
// Shared definitions for the self-clearing synchronous RAM.
package ram_sync_clear_pkg;

    // Controller states: the array is either user-accessible or being swept to zero.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Read-during-write behaviour when a read and a write hit the same edge.
    localparam int RD_FIRST = 0;  // read returns the previous word
    localparam int WR_FIRST = 1;  // read returns the word being written

endpackage

// File: rtl/ram_sync_clear_array_core.sv
// Single-port storage: synchronous write, registered synchronous read.
// The read register is resettable so the output has a defined value after
// reset; the array itself is never reset.
module ram_array_core
    import ram_sync_clear_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 14,
    parameter int READ_MODE = RD_FIRST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    // Select the next read word, honouring the read-during-write mode.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            if ((READ_MODE == WR_FIRST) && we) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem[addr];
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Storage write port; contents survive reset and are zeroed only by the sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read data, held when no read is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= {WIDTH{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_sync_clear.sv
// Parametrised single-port RAM with a registered read, valid flag and a
// hardware zero-fill engine that sweeps the whole array after reset or on
// request. User accesses are ignored while the sweep owns the array.
module ram_sync_clear
    import ram_sync_clear_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 14,
    parameter int READ_MODE = RD_FIRST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in_value,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic              read_en,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] CNT_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_d, state_q;
    logic [ADDR_W-1:0] cnt_d, cnt_q;
    logic              busy_d, busy_q;
    logic              out_valid_d, out_valid_q;

    logic              mem_we_s;
    logic              mem_re_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [WIDTH-1:0]  mem_wdata_s;

    // Next-state logic and array port mux: the sweep owns the port in CLEAR,
    // the user owns it in IDLE unless a clear request pre-empts the access.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        mem_addr_s  = address;
        mem_wdata_s = in_value;
        case (state_q)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = cnt_q;
                mem_wdata_s = {WIDTH{1'b0}};
                cnt_d       = cnt_q + CNT_ONE;
                // The last-address compare ends the sweep; the wrap of cnt is harmless.
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_CLEAR;
                    busy_d  = 1'b1;
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    // Clear wins over a simultaneous load/read; no write on this edge.
                    state_d = ST_CLEAR;
                    cnt_d   = {ADDR_W{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    mem_we_s    = load;
                    mem_re_s    = read_en;
                    out_valid_d = read_en;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = {ADDR_W{1'b0}};
                busy_d  = 1'b1;
            end
        endcase
    end

    // Controller state and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= {ADDR_W{1'b0}};
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    ram_array_core #(
        .WIDTH     (WIDTH),
        .ADDR_W    (ADDR_W),
        .READ_MODE (READ_MODE)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .addr  (mem_addr_s),
        .wdata (mem_wdata_s),
        .rdata (out)
    );

    assign busy      = busy_q;
    assign out_valid = out_valid_q;

endmodule
